// File: rtl/led_activity_driver.sv
// Purpose: debounce SoC GPIO activity, stretch short pulses, PWM-dim the LEDs, blink a heartbeat when idle.
// Latency: gpio_in -> leds is 2 sync + FILTER_CYCLES filter + 1 output register cycles.
// Backpressure: none; free-running display path with no flow control. Heartbeat FSM built only with LED_HEARTBEAT_EN.
module led_activity_driver #(
    parameter int CLK_HZ        = 50000000,
    parameter int FILTER_CYCLES = 4,
    parameter int STRETCH_MS    = 20,
    parameter int IDLE_MS       = 2000
) (
    input  logic       CLK50,
    input  logic       rst,
    input  logic [7:0] gpio_in,
    input  logic [7:0] brightness,
    output logic [7:0] leds,
    output logic       heartbeat
);

    localparam int DIV_RAW = CLK_HZ / 1000;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = (STRETCH_MS > 0) ? $clog2(STRETCH_MS + 1) : 1;
    localparam int FW      = 8;

    localparam logic [PW-1:0] PRE_LAST     = PW'(DIV - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_MS);
    localparam logic [FW-1:0] FILT_LAST    = FW'(FILTER_CYCLES - 1);

    logic [7:0]          sync1, sync2, filtered, filt_next, rise;
    logic [7:0][FW-1:0]  fcnt, fcnt_next;
    logic [PW-1:0]       presc;
    logic                tick;
    logic [7:0][SW-1:0]  stretch;
    logic [7:0]          stretch_nz, led_req;
    logic [7:0]          pwm_cnt, duty;
    logic                pwm_on;
    logic [7:0]          leds_next;
    logic                hb_next;

    // Per-bit filter: a bit only flips after the synced value has disagreed for FILTER_CYCLES cycles in a row.
    always_comb begin
        filt_next = filtered;
        fcnt_next = '0;
        for (int i = 0; i < 8; i++) begin
            if (sync2[i] != filtered[i]) begin
                if (fcnt[i] == FILT_LAST) filt_next[i] = sync2[i];
                else                      fcnt_next[i] = fcnt[i] + FW'(1);
            end
        end
        rise = filt_next & ~filtered;
    end

    // Two-flop synchronizer followed by the filter state.
    always_ff @(posedge CLK50) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            filtered <= '0;
            fcnt     <= '0;
        end else begin
            sync1    <= gpio_in;
            sync2    <= sync1;
            filtered <= filt_next;
            fcnt     <= fcnt_next;
        end
    end

    assign tick = (presc == PRE_LAST);

    // Millisecond prescaler; wraps to zero on the tick cycle.
    always_ff @(posedge CLK50) begin
        if (rst)       presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    // Pulse stretchers: a rising edge reloads (and beats a coincident tick), ticks count down to zero.
    always_ff @(posedge CLK50) begin
        if (rst) begin
            stretch <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (rise[i])                         stretch[i] <= STRETCH_LOAD;
                else if (tick && stretch[i] != '0)   stretch[i] <= stretch[i] - SW'(1);
            end
        end
    end

    // Activity request per LED: filtered level or a still-running stretch.
    always_comb begin
        stretch_nz = '0;
        for (int i = 0; i < 8; i++) stretch_nz[i] = |stretch[i];
        led_req = filtered | stretch_nz;
    end

    // Free-running PWM; duty only updates at the wrap so a period is never split.
    always_ff @(posedge CLK50) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF) duty <= brightness;
        end
    end

    assign pwm_on = (pwm_cnt < duty);

`ifdef LED_HEARTBEAT_EN
    localparam int            IW       = (IDLE_MS > 0) ? $clog2(IDLE_MS + 1) : 1;
    localparam logic [IW-1:0] IDLE_END = IW'(IDLE_MS);
    localparam logic [8:0]    HB_LAST  = 9'd499;

    typedef enum logic [1:0] {ACTIVE, IDLE_WAIT, HEARTBEAT} state_t;

    state_t        state, state_next;
    logic [IW-1:0] idle_cnt;
    logic [8:0]    hb_ms;
    logic          hb_phase;
    logic [7:0]    hb_duty;
    logic          hb_on;

    // State register.
    always_ff @(posedge CLK50) begin
        if (rst) state <= ACTIVE;
        else     state <= state_next;
    end

    // Next-state logic: drift to heartbeat after IDLE_MS of silence, any activity pulls back to ACTIVE.
    always_comb begin
        state_next = state;
        case (state)
            ACTIVE:    if (led_req == '0)          state_next = IDLE_WAIT;
            IDLE_WAIT: if (led_req != '0)          state_next = ACTIVE;
                       else if (idle_cnt == IDLE_END) state_next = HEARTBEAT;
            HEARTBEAT: if (rise != '0)             state_next = ACTIVE;
            default:                               state_next = ACTIVE;
        endcase
    end

    // Idle ms counter (saturating) and 500 ms blink timer; blink phase restarts "on" outside heartbeat.
    always_ff @(posedge CLK50) begin
        if (rst) begin
            idle_cnt <= '0;
            hb_ms    <= '0;
            hb_phase <= 1'b1;
        end else begin
            if (state == ACTIVE)                      idle_cnt <= '0;
            else if (tick && idle_cnt != IDLE_END)    idle_cnt <= idle_cnt + IW'(1);

            if (state != HEARTBEAT) begin
                hb_ms    <= '0;
                hb_phase <= 1'b1;
            end else if (tick) begin
                if (hb_ms == HB_LAST) begin
                    hb_ms    <= '0;
                    hb_phase <= ~hb_phase;
                end else begin
                    hb_ms <= hb_ms + 9'd1;
                end
            end
        end
    end

    // Output decode keyed on the next state so heartbeat drops on the same edge activity returns.
    always_comb begin
        hb_duty   = (duty == 8'd0) ? 8'd1 : duty;
        hb_on     = (pwm_cnt < hb_duty);
        hb_next   = (state_next == HEARTBEAT);
        leds_next = hb_next ? {7'b0, hb_phase & hb_on} : (led_req & {8{pwm_on}});
    end
`else
    // Without the heartbeat option the LEDs purely follow gated activity.
    always_comb begin
        hb_next   = 1'b0;
        leds_next = led_req & {8{pwm_on}};
    end
`endif

    // Registered outputs.
    always_ff @(posedge CLK50) begin
        if (rst) begin
            leds      <= '0;
            heartbeat <= 1'b0;
        end else begin
            leds      <= leds_next;
            heartbeat <= hb_next;
        end
    end

endmodule

// File: tb/tb_led_activity_driver.sv
// Directed bench for led_activity_driver at 10 cycles/ms, FILTER_CYCLES=4, STRETCH_MS=3, IDLE_MS=5.
// n counts clock edges since the last reset edge: after edge n, pwm_cnt = n%256, and ms ticks land on edges n%10==0.
// Duty reloads on edges n%256==0, so LEDs stay dark for the first 256 cycles after reset.
module tb_led_activity_driver;

    logic       CLK50 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] brightness = 8'd255;
    logic [7:0] leds;
    logic       heartbeat;

    int n = 0;
    int checks = 0;
    int passes = 0;

    led_activity_driver #(
        .CLK_HZ        (10000),
        .FILTER_CYCLES (4),
        .STRETCH_MS    (3),
        .IDLE_MS       (5)
    ) dut (
        .CLK50      (CLK50),
        .rst        (rst),
        .gpio_in    (gpio_in),
        .brightness (brightness),
        .leds       (leds),
        .heartbeat  (heartbeat)
    );

    always #5 CLK50 = ~CLK50;

    always @(posedge CLK50) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    task automatic step_to(input int target);
        while (n < target) begin
            @(posedge CLK50);
            #1;
        end
    endtask

    task automatic step1();
        @(posedge CLK50);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h (n=%0d)", tag, obs, exp, n);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b (n=%0d)", tag, obs, exp, n);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        int hi;

        // Reset holds everything dark.
        rst = 1'b1;
        gpio_in = 8'h01;
        brightness = 8'd255;
        repeat (3) step1();
        check8("rst_leds", leds, 8'h00);
        check1("rst_hb", heartbeat, 1'b0);
        rst = 1'b0;

        // Duty is 0 until the first wrap, then 255.
        step_to(100);
        check8("duty_zero_before_wrap", leds, 8'h00);
        step_to(260);
        check8("first_period_on", leds, 8'h01);

        // Glitch: 3 cycles high never reaches the filter threshold.
        step_to(300);
        gpio_in = 8'h05;
        step_to(303);
        gpio_in = 8'h01;
        while (n < 330) begin
            step1();
            check8("glitch_led2", leds & 8'h04, 8'h00);
        end

        // Stretch: 6 cycles high -> filtered rises at edge 406, ticks at 410/420/430 drain it.
        step_to(400);
        gpio_in = 8'h05;
        step_to(406);
        gpio_in = 8'h01;
        check8("stretch_not_yet", leds & 8'h04, 8'h00);
        while (n < 430) begin
            step1();
            check8("stretch_on", leds & 8'h04, 8'h04);
        end
        step1();
        check8("stretch_released", leds & 8'h04, 8'h00);

        // Rising edge on a tick edge (500): reload must win, so the LED holds until edge 530.
        step_to(494);
        gpio_in = 8'h09;
        step_to(500);
        gpio_in = 8'h01;
        step_to(525);
        check8("reload_beats_tick", leds & 8'h08, 8'h08);
        step_to(530);
        check8("reload_last_ms", leds & 8'h08, 8'h08);
        step_to(531);
        check8("reload_released", leds & 8'h08, 8'h00);

        // PWM: duty 64 loads at edge 768; change to 128 mid-period must wait for edge 1024.
        step_to(600);
        gpio_in = 8'hFF;
        brightness = 8'd64;
        step_to(768);
        hi = 0;
        while (n < 1024) begin
            step1();
            if (n == 800) brightness = 8'd128;
            if (n == 832) check8("pwm_last_on", leds, 8'hFF);
            if (n == 833) check8("pwm_first_off", leds, 8'h00);
            if (n == 870) check8("duty_held_mid_period", leds, 8'h00);
            if (leds == 8'hFF) hi++;
        end
        check_int("pwm_high_count_64", hi, 64);
        hi = 0;
        while (n < 1280) begin
            step1();
            if (leds == 8'hFF) hi++;
        end
        check_int("pwm_high_count_128", hi, 128);

        // Brightness 0 (loads at edge 1536) keeps LEDs dark whatever gpio_in does.
        step_to(1300);
        brightness = 8'd0;
        step_to(1536);
        while (n < 1600) begin
            step1();
            if (n == 1540) gpio_in = 8'hA5;
            if (n == 1560) gpio_in = 8'h5A;
            if (n == 1580) gpio_in = 8'hFF;
            check8("zero_duty_dark", leds, 8'h00);
        end
        brightness = 8'd255;

        // Reset during a stretch aborts it on the next edge.
        step_to(1800);
        gpio_in = 8'h00;
        step_to(1830);
        gpio_in = 8'h10;
        step_to(1836);
        gpio_in = 8'h00;
        step_to(1845);
        check8("stretch_before_rst", leds, 8'h10);
        rst = 1'b1;
        step1();
        check8("rst_in_stretch_leds", leds, 8'h00);
        check1("rst_in_stretch_hb", heartbeat, 1'b0);
        step1();
        rst = 1'b0;

`ifdef LED_HEARTBEAT_EN
        // Idle: IDLE_WAIT from edge 1, idle counter hits 5 at edge 50, HEARTBEAT at edge 51.
        step_to(50);
        check1("hb_not_before_idle", heartbeat, 1'b0);
        step_to(51);
        check1("hb_enter", heartbeat, 1'b1);
        step_to(3000);
        check8("hb_on_phase", leds, 8'h01);
        step_to(5050);
        check8("hb_before_toggle", leds, 8'h01);
        step_to(5051);
        check8("hb_toggle_off", leds, 8'h00);
        step_to(10050);
        check8("hb_off_phase", leds, 8'h00);
        step_to(10051);
        check8("hb_toggle_on", leds, 8'h01);

        // Activity on bit 5: filtered rises at edge 10106 and heartbeat drops on that edge.
        step_to(10100);
        gpio_in = 8'h20;
        step_to(10105);
        check1("hb_hold_until_rise", heartbeat, 1'b1);
        step_to(10106);
        check1("hb_exit", heartbeat, 1'b0);
        check8("hb_dropped", leds, 8'h00);
        step_to(10107);
        check8("active_after_hb", leds, 8'h20);

        // Back to idle: stretch ends at 10130, heartbeat again from edge 10181; then reset it.
        step_to(10120);
        gpio_in = 8'h00;
        step_to(10185);
        check1("hb_reentry", heartbeat, 1'b1);
        check8("hb_reentry_leds", leds, 8'h01);
        rst = 1'b1;
        step1();
        check8("rst_in_hb_leds", leds, 8'h00);
        check1("rst_in_hb_hb", heartbeat, 1'b0);
        step1();
        rst = 1'b0;
`else
        // No heartbeat option: long silence keeps everything dark and heartbeat low.
        while (n < 400) begin
            step1();
            check1("no_hb_idle", heartbeat, 1'b0);
            check8("no_hb_leds", leds, 8'h00);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
